// File: rtl/chrom_serial_loader.sv
// Byte-stream chromosome loader: assembles a framed payload (SOF + NBYTES, LSB byte first)
// into a shadow register and commits it to cromossomo atomically. Optional checksum: CHROM_LOADER_CHK_EN.
module chrom_serial_loader #(
  parameter int         ROW       = 2,
  parameter int         COL       = 2,
  parameter int         OUT       = 2,
  parameter int         BITS_ELEM = 1,
  parameter logic [7:0] SOF       = 8'hA5,
  localparam int        CHROM_W   = ROW*COL*16 + BITS_ELEM*OUT,
  localparam int        NBYTES    = (CHROM_W + 7) / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               abort,
  output logic [CHROM_W-1:0] cromossomo,
  output logic               chrom_update,
  output logic               busy,
  output logic               frame_err,
  output logic [7:0]         frame_cnt,
  output logic [1:0]         dbg_state
);

  localparam int IDX_W = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [CHROM_W-1:0] r_shadow;
  logic [CHROM_W-1:0] r_chrom;
  logic [7:0]         r_frame_cnt;
  logic               w_in_ready;
  logic               w_busy;
  logic               w_update;
  logic               w_accept;
  logic               w_sof;
  logic               w_last;
  logic               w_load_byte;
  logic [CHROM_W-1:0] w_mask;
  logic [CHROM_W-1:0] w_data;

  // Handshake: a byte moves on a rising edge only when in_valid && in_ready; with in_ready low
  // the sender keeps the byte on in_data and nothing is consumed.
  assign w_accept    = in_valid && w_in_ready;
  assign w_sof       = (in_data == SOF);
  assign w_last      = (r_idx == IDX_W'(NBYTES - 1));
  assign w_load_byte = (r_state == S_LOAD) && w_accept && !abort;

  // Lane select for byte r_idx; bits shifted past CHROM_W fall off, dropping the last byte's spare bits.
  assign w_mask = CHROM_W'(8'hFF) << {r_idx, 3'b000};
  assign w_data = CHROM_W'(in_data) << {r_idx, 3'b000};

`ifdef CHROM_LOADER_CHK_EN
  logic [7:0] r_chk;
  logic       r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= (r_state == S_CHECK) && w_accept && !abort && (in_data != r_chk);
      if (r_state == S_IDLE && w_accept && w_sof) begin
        r_chk <= '0;
      end else if (w_load_byte) begin
        r_chk <= r_chk ^ in_data;
      end
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_sof) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_accept && w_last) begin
`ifdef CHROM_LOADER_CHK_EN
          w_next = S_CHECK;
`else
          w_next = S_COMMIT;
`endif
        end
      end
`ifdef CHROM_LOADER_CHK_EN
      S_CHECK: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_accept) begin
          w_next = (in_data == r_chk) ? S_COMMIT : S_IDLE;
        end
      end
`endif
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b1;
    w_busy     = 1'b1;
    w_update   = 1'b0;
    case (r_state)
      S_IDLE:   w_busy = 1'b0;
      S_COMMIT: begin
        w_in_ready = 1'b0;
        w_update   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_shadow    <= '0;
      r_chrom     <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept && w_sof) begin
        r_idx <= '0;
      end else if (w_load_byte) begin
        r_idx    <= r_idx + 1'b1;
        r_shadow <= (r_shadow & ~w_mask) | (w_data & w_mask);
      end
      if (r_state == S_COMMIT) begin
        r_chrom     <= r_shadow;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign busy         = w_busy;
  assign chrom_update = w_update;
  assign cromossomo   = r_chrom;
  assign frame_cnt    = r_frame_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Directed + randomized bench for chrom_serial_loader with a frame-level reference model.
module tb_chrom_serial_loader;

  localparam int CW = 66;
  localparam int NB = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          abort = 1'b0;
  logic          in_ready;
  logic [CW-1:0] cromossomo;
  logic          chrom_update;
  logic          busy;
  logic          frame_err;
  logic [7:0]    frame_cnt;
  logic [1:0]    dbg_state;

  chrom_serial_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .cromossomo(cromossomo), .chrom_update(chrom_update), .busy(busy),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_cur = '0;
  logic          upd_pend = 1'b0;
  int            n_upd = 0;
  int            n_notready = 0;
  int            n_ferr = 0;
  int            exp_cnt = 0;
  logic [7:0]    pl[NB];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: payload bytes laid out little-endian, truncated to the chromosome width.
  function automatic logic [CW-1:0] assemble();
    logic [71:0] acc = '0;
    for (int k = 0; k < NB; k++) acc = acc | (72'(pl[k]) << (8 * k));
    return acc[CW-1:0];
  endfunction

  // Scoreboard: cromossomo must equal the last committed frame, advancing only after an update pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      upd_pend = 1'b0;
      exp_cur  = '0;
      check("cromossomo_in_reset", cromossomo, exp_cur);
    end else begin
      if (upd_pend) begin
        if (exp_q.size() == 0) check("unexpected_update_q", exp_q.size(), 1);
        else exp_cur = exp_q.pop_front();
      end
      check("cromossomo", cromossomo, exp_cur);
      upd_pend = chrom_update;
      if (chrom_update) n_upd++;
      if (!in_ready) n_notready++;
      if (frame_err) n_ferr++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input bit bad_chk);
    logic [7:0] x = 8'h00;
    send_byte(8'hA5);
    for (int k = 0; k < NB; k++) begin
      send_byte(pl[k]);
      x = x ^ pl[k];
    end
`ifdef CHROM_LOADER_CHK_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x);
`endif
    if (!bad_chk) begin
      exp_q.push_back(assemble());
      exp_cnt++;
    end
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NB; k++) pl[k] = 8'($urandom);
  endtask

  initial begin
    int base_upd;
    int base_nr;
    logic [7:0] junk;

    // Reset values
    #1;
    check("rst_cromossomo", cromossomo, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_chrom_update", chrom_update, 0);
    check("rst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Incrementing payload 01..09
    for (int k = 0; k < NB; k++) pl[k] = 8'(k + 1);
    base_upd = n_upd;
    send_frame(1'b0);
    idle(2);
    check("inc_cromossomo", cromossomo, 66'h1_0807060504030201);
    check("inc_update_pulses", n_upd - base_upd, 1);
    check("inc_frame_cnt", frame_cnt, 8'(exp_cnt));
    check("inc_busy", busy, 0);

    // Leading non-SOF bytes are dropped, then an all-ones frame
    send_byte(8'h00);
    send_byte(8'h3C);
    for (int i = 0; i < 3; i++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk);
    end
    for (int k = 0; k < NB; k++) pl[k] = 8'hFF;
    send_frame(1'b0);
    idle(2);
    check("ones_cromossomo", cromossomo, {CW{1'b1}});
    check("ones_no_frame_err", n_ferr, 0);
    check("ones_frame_cnt", frame_cnt, 8'(exp_cnt));

    // Random frames, SOF value allowed inside payload
    for (int f = 0; f < 4; f++) begin
      rand_payload();
      if (f == 1) pl[3] = 8'hA5;
      send_frame(1'b0);
      idle($urandom_range(1, 3));
    end
    check("rand_frame_cnt", frame_cnt, 8'(exp_cnt));

    // Abort mid-frame with a byte offered the same cycle
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_busy_drop", busy, 0);
    idle(2);
    check("abort_frame_cnt", frame_cnt, 8'(exp_cnt));
    check("abort_no_frame_err", n_ferr, 0);
    rand_payload();
    send_frame(1'b0);
    idle(2);
    check("post_abort_frame_cnt", frame_cnt, 8'(exp_cnt));

`ifdef CHROM_LOADER_CHK_EN
    // Good checksum commits, corrupted checksum is rejected
    for (int k = 0; k < NB; k++) pl[k] = 8'(k + 1);
    send_frame(1'b0);
    idle(2);
    check("chk_good_frame_cnt", frame_cnt, 8'(exp_cnt));
    base_upd = n_upd;
    send_frame(1'b1);
    idle(3);
    check("chk_bad_frame_err", n_ferr, 1);
    check("chk_bad_no_update", n_upd - base_upd, 0);
    check("chk_bad_frame_cnt", frame_cnt, 8'(exp_cnt));
`endif

    // Back-to-back frames with in_valid held high
    base_nr = n_notready;
    rand_payload();
    send_frame(1'b0);
    rand_payload();
    send_frame(1'b0);
    idle(3);
    check("b2b_notready_cycles", n_notready - base_nr, 2);
    check("b2b_frame_cnt", frame_cnt, 8'(exp_cnt));

    // Asynchronous reset in the middle of a payload
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_cnt = 0;
    check("arst_cromossomo", cromossomo, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_chrom_update", chrom_update, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_payload();
    send_frame(1'b0);
    idle(2);
    check("arst_recover_frame_cnt", frame_cnt, 8'(exp_cnt));
    check("arst_recover_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
